// File: rtl/histogram_pkg.sv
// Shared types and the counter-increment helper for the histogram engine.
package histogram_pkg;

  localparam int unsigned CNT_MAX_W = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Next count for a cnt_w-bit counter; ovf flags a hit on the all-ones value.
  function automatic logic [CNT_MAX_W-1:0] sat_inc(
    input  logic [CNT_MAX_W-1:0] value,
    input  int unsigned          cnt_w,
    input  logic                 saturate,
    output logic                 ovf
  );
    logic [CNT_MAX_W:0] top;
    top = ((CNT_MAX_W+1)'(1) << cnt_w) - (CNT_MAX_W+1)'(1);
    ovf = ({1'b0, value} == top);
    if (ovf) begin
      return saturate ? value : '0;
    end
    return value + 1'b1;
  endfunction

endpackage

// File: rtl/hist_ram.sv
// Simple dual-port RAM: one synchronous read port, one write port, read-old-data on collision.
module hist_ram #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/histogram_engine.sv
// Histogram accumulator: two-stage read-modify-write over hist_ram with write forwarding,
// hardware clear sweep, shared read-out port and a running sample total.
module histogram_engine
  import histogram_pkg::*;
#(
  parameter int unsigned BIN_W    = 7,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned TOT_W    = BIN_W + CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear_req,
  input  logic             sample_valid,
  input  logic [BIN_W-1:0] sample_bin,
  output logic             sample_ready,
  input  logic             rd_req,
  input  logic [BIN_W-1:0] rd_addr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             overflow,
  output logic [TOT_W-1:0] total
);

  state_t             state_q;
  logic [BIN_W-1:0]   sweep_q;
  logic               s1_v_q;
  logic [BIN_W-1:0]   s1_bin_q;
  logic               fwd_v_q;
  logic [BIN_W-1:0]   fwd_addr_q;
  logic [CNT_W-1:0]   fwd_data_q;
  logic               rd_v_q;
  logic [BIN_W-1:0]   rd_addr_q;
  logic               ovf_q;
  logic [TOT_W-1:0]   total_q;

  logic               run;
  logic               rd_acc;
  logic               smp_acc;
  logic [CNT_W-1:0]   old_cnt;
  logic [CNT_W-1:0]   new_cnt;
  logic               inc_ovf;
  logic               ram_we;
  logic [BIN_W-1:0]   ram_waddr;
  logic [CNT_W-1:0]   ram_wdata;
  logic [BIN_W-1:0]   ram_raddr;
  logic [CNT_W-1:0]   ram_q;

  // A read wins the single RAM read port over a sample.
  assign run          = (state_q == RUN);
  assign rd_acc       = run && rd_req && !clear_req;
  assign smp_acc      = run && sample_valid && !rd_req && !clear_req;
  assign sample_ready = run && !rd_req && !clear_req;
  assign ram_raddr    = rd_req ? rd_addr : sample_bin;

  assign busy     = (state_q == CLEAR);
  assign rd_valid = rd_v_q;
  assign overflow = ovf_q;
  assign total    = total_q;

  // S1: the RAM returns stale data if last cycle wrote the same bin, so take the written value.
  always_comb begin
    old_cnt = ram_q;
    if (fwd_v_q && (fwd_addr_q == s1_bin_q)) begin
      old_cnt = fwd_data_q;
    end
    inc_ovf = 1'b0;
    new_cnt = CNT_W'(sat_inc(CNT_MAX_W'(old_cnt), CNT_W, SATURATE != 0, inc_ovf));
  end

  always_comb begin
    ram_we    = s1_v_q;
    ram_waddr = s1_bin_q;
    ram_wdata = new_cnt;
    if (state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_q;
      ram_wdata = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_v_q) begin
      rd_data = (fwd_v_q && (fwd_addr_q == rd_addr_q)) ? fwd_data_q : ram_q;
    end
  end

  hist_ram #(
    .AW (BIN_W),
    .DW (CNT_W)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_q)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= CLEAR;
      sweep_q    <= '0;
      s1_v_q     <= 1'b0;
      s1_bin_q   <= '0;
      fwd_v_q    <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
      rd_v_q     <= 1'b0;
      rd_addr_q  <= '0;
      ovf_q      <= 1'b0;
      total_q    <= '0;
    end else begin
      fwd_v_q    <= ram_we;
      fwd_addr_q <= ram_waddr;
      fwd_data_q <= ram_wdata;
      s1_v_q     <= smp_acc;
      s1_bin_q   <= sample_bin;
      rd_v_q     <= rd_acc;
      rd_addr_q  <= rd_addr;
      case (state_q)
        CLEAR: begin
          sweep_q <= sweep_q + 1'b1;
          if (&sweep_q) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (s1_v_q && inc_ovf) begin
            ovf_q <= 1'b1;
          end
          if (smp_acc) begin
            total_q <= total_q + 1'b1;
          end
          // The in-flight S1 write still lands this cycle; the sweep then wipes everything.
          if (clear_req) begin
            state_q <= CLEAR;
            sweep_q <= '0;
            ovf_q   <= 1'b0;
            total_q <= '0;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_histogram_engine.sv
// Bench for histogram_engine: vector table plus scoreboarded reads, with two narrow
// 4-bit-counter instances (saturating and wrapping) driven in lockstep.
module tb_histogram_engine;

  localparam int BIN_W = 7;
  localparam int CNT_W = 16;
  localparam int NBINS = 1 << BIN_W;
  localparam int TOT_W = BIN_W + CNT_W;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             clear_req = 1'b0;
  logic             sample_valid = 1'b0;
  logic [BIN_W-1:0] sample_bin = '0;
  logic             rd_req = 1'b0;
  logic [BIN_W-1:0] rd_addr = '0;

  logic             sample_ready, rd_valid, busy, overflow;
  logic [CNT_W-1:0] rd_data;
  logic [TOT_W-1:0] total;
  logic             s_ready, s_rd_valid, s_busy, s_ovf;
  logic [3:0]       s_rd_data;
  logic [10:0]      s_total;
  logic             w_ready, w_rd_valid, w_busy, w_ovf;
  logic [3:0]       w_rd_data;
  logic [10:0]      w_total;

  histogram_engine #(.BIN_W(BIN_W), .CNT_W(CNT_W), .SATURATE(1)) dut (
    .CLK(CLK), .RST(RST), .clear_req(clear_req), .sample_valid(sample_valid),
    .sample_bin(sample_bin), .sample_ready(sample_ready), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .overflow(overflow), .total(total));

  histogram_engine #(.BIN_W(BIN_W), .CNT_W(4), .SATURATE(1)) dut_sat (
    .CLK(CLK), .RST(RST), .clear_req(clear_req), .sample_valid(sample_valid),
    .sample_bin(sample_bin), .sample_ready(s_ready), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_valid(s_rd_valid), .rd_data(s_rd_data), .busy(s_busy),
    .overflow(s_ovf), .total(s_total));

  histogram_engine #(.BIN_W(BIN_W), .CNT_W(4), .SATURATE(0)) dut_wrap (
    .CLK(CLK), .RST(RST), .clear_req(clear_req), .sample_valid(sample_valid),
    .sample_bin(sample_bin), .sample_ready(w_ready), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_valid(w_rd_valid), .rd_data(w_rd_data), .busy(w_busy),
    .overflow(w_ovf), .total(w_total));

  always #5 CLK = ~CLK;

  typedef struct {
    int               due;
    logic [CNT_W-1:0] data;
  } rd_exp_t;

  typedef struct {
    bit v;
    int b;
    bit r;
    int a;
    bit exp_ready;
    int exp_rd;
  } vec_t;

  int      n_tests = 0;
  int      n_fail = 0;
  int      cyc = 0;
  bit      mon_en = 1'b0;
  rd_exp_t sb_q[$];
  rd_exp_t mon_e;
  int      model[NBINS];
  int      model_total = 0;
  vec_t    tbl[15];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read scoreboard: each accepted read must produce rd_valid exactly one cycle later.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
        mon_e = sb_q.pop_front();
        chk("rd_valid", 64'(rd_valid), 64'd1);
        chk("rd_data", 64'(rd_data), 64'(mon_e.data));
      end else begin
        chk("rd_valid_idle", 64'(rd_valid), 64'd0);
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NBINS; i++) model[i] = 0;
    model_total = 0;
  endtask

  // Drive one RUN cycle and update the reference model/scoreboard.
  task automatic drive(input bit v, input int b, input bit r, input int a, input bit c,
                       input int exp_rd);
    logic [CNT_W-1:0] d;
    @(posedge CLK); #1;
    sample_valid = v;
    sample_bin   = BIN_W'(b);
    rd_req       = r;
    rd_addr      = BIN_W'(a);
    clear_req    = c;
    if (c) begin
      clear_model();
    end else if (r) begin
      d = (exp_rd >= 0) ? CNT_W'(exp_rd) : CNT_W'(model[a]);
      sb_q.push_back('{due: cyc + 1, data: d});
    end else if (v) begin
      model[b]++;
      model_total++;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_flags", 64'({busy, sample_ready, rd_valid, overflow}), 64'b1000);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_total", 64'(total), 64'd0);
  endtask

  // Expect exactly NBINS busy cycles with samples refused, then RUN with cleared state.
  task automatic sweep_check(input bit v);
    clear_model();
    for (int i = 0; i < NBINS; i++) begin
      @(posedge CLK); #1;
      RST          = 1'b1;
      clear_req    = 1'b0;
      rd_req       = 1'b0;
      sample_valid = v;
      sample_bin   = BIN_W'(i);
      @(negedge CLK);
      chk("sweep_busy", 64'({busy, s_busy, w_busy, sample_ready, s_ready, w_ready}),
          64'b111000);
    end
    @(posedge CLK); #1;
    sample_valid = 1'b0;
    @(negedge CLK);
    chk("sweep_done", 64'({busy, s_busy, w_busy, sample_ready, s_ready, w_ready}),
        64'b000111);
    chk("total_cleared", 64'({total, s_total, w_total}), 64'd0);
    chk("ovf_cleared", 64'({overflow, s_ovf, w_ovf}), 64'd0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < NBINS; i++) drive(1'b0, 0, 1'b1, i, 1'b0, 0);
    drive(1'b0, 0, 1'b0, 0, 1'b0, -1);
    drive(1'b0, 0, 1'b0, 0, 1'b0, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    tbl = '{
      '{1, 5, 0, 0, 1, -1}, '{1, 5, 0, 0, 1, -1}, '{1, 5, 0, 0, 1, -1}, '{1, 5, 0, 0, 1, -1},
      '{0, 0, 1, 5, 0, 4},
      '{1, 3, 0, 0, 1, -1}, '{1, 9, 0, 0, 1, -1}, '{1, 3, 0, 0, 1, -1}, '{1, 9, 0, 0, 1, -1},
      '{1, 3, 1, 9, 0, 2},
      '{1, 3, 0, 0, 1, -1},
      '{0, 0, 1, 3, 0, 3}, '{0, 0, 1, 9, 0, 2}, '{0, 0, 1, 5, 0, 4},
      '{0, 0, 0, 0, 1, -1}
    };

    // Power-up reset and initial sweep
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    check_reset_outputs();
    mon_en = 1'b1;
    sweep_check(1'b0);
    read_all_zero();
    @(negedge CLK);
    chk("total_idle", 64'(total), 64'd0);

    // Vector table: forwarding on repeated bins and read-after-last-sample
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].r, tbl[i].a, 1'b0, tbl[i].exp_rd);
      @(negedge CLK);
      chk("tbl_ready", 64'(sample_ready), 64'(tbl[i].exp_ready));
    end
    @(negedge CLK);
    chk("tbl_total", 64'(total), 64'd9);

    // Continuous samples with reads on alternate cycles
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, int'($urandom_range(0, 15)), 1'(i % 2), int'($urandom_range(0, 15)),
            1'b0, -1);
      @(negedge CLK);
      chk("alt_ready", 64'(sample_ready), 64'((i % 2) == 0));
    end
    drive(1'b0, 0, 1'b0, 0, 1'b0, -1);
    @(negedge CLK);
    chk("alt_total", 64'(total), 64'(TOT_W'(model_total)));

    // clear_req mid-stream, with samples still offered during the sweep
    for (int i = 0; i < 5; i++) drive(1'b1, 7, 1'b0, 0, 1'b0, -1);
    drive(1'b1, 7, 1'b0, 0, 1'b1, -1);
    @(negedge CLK);
    chk("clr_ready", 64'(sample_ready), 64'd0);
    sweep_check(1'b1);
    drive(1'b0, 0, 1'b1, 7, 1'b0, 0);
    drive(1'b0, 0, 1'b0, 0, 1'b0, -1);

    // 20 hits on bin 0: 16-bit counts 20, 4-bit saturating 15, 4-bit wrapping 4
    for (int i = 0; i < 20; i++) drive(1'b1, 0, 1'b0, 0, 1'b0, -1);
    drive(1'b0, 0, 1'b1, 0, 1'b0, 20);
    drive(1'b0, 0, 1'b0, 0, 1'b0, -1);
    @(negedge CLK);
    chk("narrow_rd_valid", 64'({s_rd_valid, w_rd_valid}), 64'b11);
    chk("sat_rd_data", 64'(s_rd_data), 64'd15);
    chk("wrap_rd_data", 64'(w_rd_data), 64'd4);
    chk("narrow_ovf", 64'({s_ovf, w_ovf}), 64'b11);
    chk("wide_ovf", 64'(overflow), 64'd0);
    chk("narrow_total", 64'({s_total, w_total}), {42'd0, 11'd20, 11'd20});

    // RST mid-sweep: fill some high bins, start a clear, then reset partway through
    for (int i = 0; i < 10; i++) drive(1'b1, 100 + (i % 3), 1'b0, 0, 1'b0, -1);
    drive(1'b0, 0, 1'b0, 0, 1'b1, -1);
    repeat (5) begin
      @(posedge CLK); #1;
      clear_req = 1'b0;
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    check_reset_outputs();
    sweep_check(1'b1);
    read_all_zero();

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
